// File: rtl/stack_program_loader_pkg.sv
// Shared definitions for the stack machine and its program loader: opcodes, error codes, loader states.
// Pure declarations; no timing or flow-control behaviour of its own.
package stack_program_loader_pkg;

  localparam logic [3:0] OP_PUSHC   = 4'd0;
  localparam logic [3:0] OP_PUSHMEM = 4'd1;
  localparam logic [3:0] OP_POP     = 4'd2;
  localparam logic [3:0] OP_J       = 4'd3;
  localparam logic [3:0] OP_JZ      = 4'd4;
  localparam logic [3:0] OP_JS      = 4'd5;
  localparam logic [3:0] OP_ADD     = 4'd6;
  localparam logic [3:0] OP_SUB     = 4'd7;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_LEN  = 2'd1;
  localparam logic [1:0] ERR_OP   = 2'd2;
  localparam logic [1:0] ERR_CSUM = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_OP,
    ST_VAL,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } state_e;

  function automatic logic op_legal(input logic [7:0] b, input logic [3:0] max_op);
    return (b[7:4] == 4'd0) && (b[3:0] <= max_op);
  endfunction

endpackage

// File: rtl/loader_csum.sv
// 8-bit modulo-256 frame checksum accumulator with clear, add and compare-against-input.
// Sum updates on the edge after clr/add; match is combinational; no backpressure.
module loader_csum (
  input  logic       clk,
  input  logic       rstN,
  input  logic       clr,
  input  logic       add,
  input  logic [7:0] din,
  output logic [7:0] sum,
  output logic       match
);

  logic [7:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (clr)      sum_d = 8'd0;
    else if (add) sum_d = sum_q + din;
  end

  always_ff @(posedge clk) begin
    if (!rstN) sum_q <= 8'd0;
    else       sum_q <= sum_d;
  end

  assign sum   = sum_q;
  assign match = (din == sum_q);

endmodule

// File: rtl/stack_program_loader.sv
// Framed byte-stream loader writing validated 12-bit instructions to imem; holds the CPU until a good load.
// Latency: im_we one cycle after each value byte, done/error one cycle after the last byte; in_ready only while framing.
module stack_program_loader
  import stack_program_loader_pkg::*;
#(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5,
  parameter int MAX_OP = 7
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [11:0]       im_data,
  output logic              cpu_rstN,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code
);

  localparam int         CNT_W    = $clog2(DEPTH + 1);
  localparam logic [7:0] DEPTH_B  = 8'(DEPTH);
  localparam logic [3:0] MAX_OP_B = 4'(MAX_OP);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        op_q, op_d;
  logic              im_we_q, im_we_d;
  logic [ADDR_W-1:0] im_addr_q, im_addr_d;
  logic [11:0]       im_data_q, im_data_d;
  logic [1:0]        err_q, err_d;

  logic       xfer, csum_clr, csum_add, csum_match;
  logic [7:0] csum_sum;

  loader_csum u_csum (
    .clk   (clk),
    .rstN  (rstN),
    .clr   (csum_clr),
    .add   (csum_add),
    .din   (in_data),
    .sum   (csum_sum),
    .match (csum_match)
  );

  assign in_ready = (state_q == ST_HDR) || (state_q == ST_OP) ||
                    (state_q == ST_VAL) || (state_q == ST_CSUM);
  assign busy     = in_ready;
  assign done     = (state_q == ST_DONE);
  assign error    = (state_q == ST_ERR);
  // A restart from DONE pulls the CPU back into reset in the same cycle as the start pulse.
  assign cpu_rstN = done && !start;
  assign xfer     = in_valid && in_ready;

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    addr_d    = addr_q;
    op_d      = op_q;
    im_we_d   = 1'b0;
    im_addr_d = im_addr_q;
    im_data_d = im_data_q;
    err_d     = err_q;
    csum_clr  = 1'b0;
    csum_add  = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_d  = ST_HDR;
          csum_clr = 1'b1;
          addr_d   = '0;
          err_d    = ERR_NONE;
        end
      end
      ST_HDR: begin
        if (xfer) begin
          if (in_data == 8'd0 || in_data > DEPTH_B) begin
            state_d = ST_ERR;
            err_d   = ERR_LEN;
          end else begin
            rem_d    = CNT_W'(in_data);
            csum_add = 1'b1;
            state_d  = ST_OP;
          end
        end
      end
      ST_OP: begin
        if (xfer) begin
          if (!op_legal(in_data, MAX_OP_B)) begin
            state_d = ST_ERR;
            err_d   = ERR_OP;
          end else begin
            op_d     = in_data[3:0];
            csum_add = 1'b1;
            state_d  = ST_VAL;
          end
        end
      end
      ST_VAL: begin
        if (xfer) begin
          csum_add  = 1'b1;
          im_we_d   = 1'b1;
          im_addr_d = addr_q;
          im_data_d = {op_q, in_data};
          addr_d    = addr_q + ADDR_W'(1);
          rem_d     = rem_q - CNT_W'(1);
          state_d   = (rem_q == CNT_W'(1)) ? ST_CSUM : ST_OP;
        end
      end
      ST_CSUM: begin
        if (xfer) begin
          if (csum_match) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ERR;
            err_d   = ERR_CSUM;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      state_q   <= ST_IDLE;
      rem_q     <= '0;
      addr_q    <= '0;
      op_q      <= '0;
      im_we_q   <= 1'b0;
      im_addr_q <= '0;
      im_data_q <= '0;
      err_q     <= ERR_NONE;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      addr_q    <= addr_d;
      op_q      <= op_d;
      im_we_q   <= im_we_d;
      im_addr_q <= im_addr_d;
      im_data_q <= im_data_d;
      err_q     <= err_d;
    end
  end

  assign im_we    = im_we_q;
  assign im_addr  = im_addr_q;
  assign im_data  = im_data_q;
  assign err_code = err_q;

endmodule

// File: tb/tb_stack_program_loader.sv
// Randomized bench for stack_program_loader against a frame-level reference model of the loader.
module tb_stack_program_loader;

  logic        clk = 1'b0;
  logic        rstN, start, in_valid, in_ready, im_we, cpu_rstN, busy, done, error;
  logic [7:0]  in_data;
  logic [4:0]  im_addr;
  logic [11:0] im_data;
  logic [1:0]  err_code;

  always #5 clk = ~clk;

  stack_program_loader #(.DEPTH(32), .ADDR_W(5), .MAX_OP(7)) dut (
    .clk(clk), .rstN(rstN), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .im_we(im_we), .im_addr(im_addr), .im_data(im_data),
    .cpu_rstN(cpu_rstN), .busy(busy), .done(done), .error(error), .err_code(err_code)
  );

  int          n_checks = 0;
  int          n_err    = 0;
  logic [7:0]  frame[$];
  logic [16:0] exp_w[$];
  logic [16:0] got_w[$];
  int          consumed, exp_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) if (im_we === 1'b1) got_w.push_back({im_addr, im_data});

  // Frame-level meaning: how many bytes get accepted, what lands in memory, how the load ends.
  task automatic model();
    int n, s, op, val;
    exp_w.delete();
    exp_err  = 0;
    n        = int'(frame[0]);
    consumed = 1;
    if (n == 0 || n > 32) begin
      exp_err = 1;
      return;
    end
    s = n;
    for (int i = 0; i < n; i++) begin
      op = int'(frame[1 + 2 * i]);
      consumed++;
      if (op > 7) begin
        exp_err = 2;
        return;
      end
      val = int'(frame[2 + 2 * i]);
      consumed++;
      exp_w.push_back({5'(i), 4'(op), 8'(val)});
      s = (s + op + val) % 256;
    end
    consumed++;
    if (int'(frame[2 * n + 1]) != s) exp_err = 3;
  endtask

  task automatic gen_frame(input int n, input int bad_op_at, input bit bad_csum);
    int s, op, val;
    frame.delete();
    frame.push_back(8'(n));
    s = n;
    for (int i = 0; i < n; i++) begin
      op  = (i == bad_op_at) ? int'($urandom_range(8, 255)) : int'($urandom_range(0, 7));
      val = int'($urandom_range(0, 255));
      frame.push_back(8'(op));
      frame.push_back(8'(val));
      s = (s + op + val) % 256;
    end
    frame.push_back(8'(bad_csum ? s + 1 : s));
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_ready", 32'(in_ready), 32'd1);
    check("start_busy", 32'(busy), 32'd1);
  endtask

  task automatic run_frame(input string name, input int gap, input int start_at);
    int idx, cyc;
    model();
    got_w.delete();
    do_start();
    idx = 0;
    cyc = 0;
    while (idx < consumed && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      start = (idx == start_at);
      if (int'($urandom_range(0, 99)) < gap) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
      end else begin
        in_valid = 1'b1;
        in_data  = frame[idx];
      end
      if (in_valid && in_ready) idx++;
    end
    if (idx < consumed) check({name, "_timeout"}, 32'(idx), 32'(consumed));
    if (gap == 0) check({name, "_cycles"}, 32'(cyc), 32'(consumed));
    @(negedge clk);
    in_valid = 1'b0;
    start    = 1'b0;
    if (exp_err == 0) begin
      check({name, "_done"}, 32'(done), 32'd1);
      check({name, "_error"}, 32'(error), 32'd0);
      check({name, "_cpu_rstN"}, 32'(cpu_rstN), 32'd1);
      check({name, "_busy"}, 32'(busy), 32'd0);
    end else begin
      check({name, "_done"}, 32'(done), 32'd0);
      check({name, "_error"}, 32'(error), 32'd1);
      check({name, "_cpu_rstN"}, 32'(cpu_rstN), 32'd0);
      check({name, "_ready"}, 32'(in_ready), 32'd0);
    end
    check({name, "_err_code"}, 32'(err_code), 32'(exp_err));
    check({name, "_nwrites"}, 32'(got_w.size()), 32'(exp_w.size()));
    for (int i = 0; i < exp_w.size() && i < got_w.size(); i++)
      check($sformatf("%s_wr%0d", name, i), 32'(got_w[i]), 32'(exp_w[i]));
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_in_ready"}, 32'(in_ready), 32'd0);
    check({name, "_im_we"}, 32'(im_we), 32'd0);
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_done"}, 32'(done), 32'd0);
    check({name, "_error"}, 32'(error), 32'd0);
    check({name, "_im_addr"}, 32'(im_addr), 32'd0);
    check({name, "_im_data"}, 32'(im_data), 32'd0);
    check({name, "_err_code"}, 32'(err_code), 32'd0);
    check({name, "_cpu_rstN"}, 32'(cpu_rstN), 32'd0);
  endtask

  initial begin
    int n, kind;
    rstN     = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'd0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rstN = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("idle");

    frame = '{8'h03, 8'h00, 8'h05, 8'h00, 8'h03, 8'h06, 8'h00, 8'h11};
    run_frame("good", 0, 3);
    frame = '{8'h00, 8'h00, 8'h00};
    run_frame("len0", 0, -1);
    frame = '{8'h21, 8'h00, 8'h00};
    run_frame("len33", 0, -1);
    frame = '{8'h02, 8'h00, 8'h07, 8'h08, 8'h00, 8'h00, 8'h00};
    run_frame("badop", 0, -1);
    frame = '{8'h01, 8'h06, 8'h00, 8'h08};
    run_frame("badcsum", 0, -1);
    frame = '{8'h01, 8'h06, 8'h00, 8'h07};
    run_frame("recover", 0, -1);
    gen_frame(32, -1, 1'b0);
    run_frame("max_len", 40, 10);

    for (int t = 0; t < 20; t++) begin
      kind = int'($urandom_range(0, 9));
      n    = int'($urandom_range(1, 32));
      if (kind == 0) gen_frame(0, -1, 1'b0);
      else if (kind == 1) gen_frame(int'($urandom_range(33, 255)), -1, 1'b0);
      else if (kind == 2) gen_frame(n, int'($urandom_range(0, n - 1)), 1'b0);
      else if (kind == 3) gen_frame(n, -1, 1'b1);
      else gen_frame(n, -1, 1'b0);
      run_frame($sformatf("rnd%0d", t), int'($urandom_range(0, 50)), int'($urandom_range(1, 4)));
    end

    // Abort a load while the loader is waiting on a value byte.
    do_start();
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'h04;
    @(negedge clk);
    in_data = 8'h01;
    @(negedge clk);
    check("midrst_in_val", 32'(in_ready), 32'd1);
    got_w.delete();
    rstN    = 1'b0;
    in_data = 8'h55;
    @(negedge clk);
    rstN     = 1'b1;
    in_valid = 1'b0;
    check_reset_outputs("midrst");
    repeat (10) @(negedge clk);
    check("midrst_no_we", 32'(got_w.size()), 32'd0);
    check("midrst_idle", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/stack_program_loader.md
# stack_program_loader

Byte-stream program loader for the 8-opcode stack machine. It accepts a framed program over a valid/ready byte interface, validates it, and writes 12-bit instructions sequentially into the machine's instruction memory. It holds the machine in reset until a complete, checksum-verified program has been written. It is the writer side of the instruction-memory read path.

## Interface
Parameters:
- DEPTH, 32, instruction memory depth; legal program length is 1..DEPTH.
- ADDR_W, 5, instruction address width; must satisfy 2**ADDR_W >= DEPTH.
- MAX_OP, 7, highest legal opcode.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rstN  in  1  reset, synchronous and active-low.
- start  in  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE and ERR.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader accepts a byte this cycle.
- im_we  out  1  instruction-memory write strobe, one cycle per instruction.
- im_addr  out  ADDR_W  write address.
- im_data  out  12  {opcode[3:0], value[7:0]}; im_data[11:8] is the opcode field.
- cpu_rstN  out  1  active-low reset to the stack machine.
- busy  out  1  load in progress.
- done  out  1  program loaded and verified.
- error  out  1  load aborted.
- err_code  out  2  0 none, 1 bad length, 2 bad opcode, 3 checksum mismatch.

## Operation
- Frame format: N (header byte), then N × {op byte, value byte}, then a checksum byte. The checksum equals the 8-bit wrap-around sum of the header byte and all 2N body bytes.
- A transfer occurs on any cycle with in_valid && in_ready.
- in_ready = 1 only in states HDR, OP, VAL and CSUM. It is decoded combinationally from the state.
- State IDLE:
  - On start: go to HDR, clear the sum, set the address counter to 0, assert busy, clear done/error/err_code.
  - cpu_rstN = 0.
- State HDR, on transfer:
  - If N == 0 or N > DEPTH: go to ERR with err_code = 1.
  - Otherwise: remaining = N, sum = N, go to OP.
- State OP, on transfer:
  - If byte[7:4] != 0 or byte[3:0] > MAX_OP: go to ERR with err_code = 2.
  - Otherwise: latch the opcode, add the byte to sum, go to VAL.
- State VAL, on transfer:
  - Add the byte to sum and register a write of {op, byte} at the current address.
  - Increment the address and decrement remaining.
  - Go to CSUM if remaining was 1, otherwise go to OP.
- State CSUM, on transfer:
  - byte == sum: go to DONE.
  - Otherwise: go to ERR with err_code = 3.
- State DONE:
  - done = 1, busy = 0, cpu_rstN = 1.
  - On start: drive cpu_rstN = 0 and begin a new load (HDR).
- State ERR:
  - error = 1, busy = 0, cpu_rstN = 0.
  - Instructions already written remain in memory and are not scrubbed.
  - On start: begin a new load (HDR).
- start is ignored while busy.
- in_data received outside a transfer has no effect.
- All sums are 8-bit modulo 256. The address counter never wraps within a legal frame; the last write is to address N-1.

## Timing
- Reset values of the outputs:
  - in_ready, im_we, busy, done, error = 0.
  - im_addr, im_data, err_code = 0.
  - cpu_rstN = 0; the machine stays held after reset until a successful load.
- rstN low at any point, including mid-load, returns the block to IDLE on the next edge. No further im_we is issued.
- start → HDR takes one cycle; in_ready rises in the cycle after the start pulse.
- im_we is registered and asserted in the cycle after the VAL-byte transfer. im_addr and im_data are valid in that same cycle.
- done/error (and cpu_rstN rising on success) assert in the cycle after the CSUM or offending byte transfers.
- With in_valid held high, a full load takes 2N+2 transfer cycles plus 1 cycle. Back-to-back bytes are accepted every cycle.
- Gaps in in_valid stall the FSM without changing state.

## Structure
- Shared package: the opcode constants (pushc 0, pushmem 1, pop 2, j 3, jz 4, js 5, add 6, sub 7), the err_code constants, and the FSM state encoding.
- The machine must import the same opcode constants.
- No sub-module is required. The checksum accumulator may optionally be split out as loader_csum (8-bit accumulate/clear/compare).

## Test plan
- Good load: start, stream 03 00 05 00 03 06 00 11.
  - Required: writes (0,0x005), (1,0x003), (2,0x600) on three single-cycle im_we pulses.
  - Then done = 1, cpu_rstN = 1, err_code = 0.
- Bad length: header 00 → error = 1, err_code = 1, no im_we. Header 21 → the same result.
- Bad opcode: stream 02 00 07 08 … → one write (0,0x007), then error with err_code = 2. in_ready drops and cpu_rstN = 0.
- Checksum mismatch: stream 01 06 00 08 (expected checksum 07) → write (0,0x600), then err_code = 3, cpu_rstN = 0. A following start and a correct frame then reach done.
- Throttling and maximum length: N = 32 with random in_valid gaps.
  - Required: 32 writes to addresses 0..31 in order, no skipped or duplicated writes, done = 1.
- Reset mid-load: rstN low for 1 cycle while in VAL.
  - Required: IDLE state, all outputs at their reset values, no im_we after reset.
  - start ignored while busy: a start pulse during a load has no effect.
